// File: rtl/dvs_pkg.sv
// Shared types and constants for the DVS sample feeder and its filter-side timing.
// Includes the saturating magnitude helper used for activity detection.
package dvs_pkg;

  localparam int SAMPLE_W         = 16;
  localparam int MAG_W            = SAMPLE_W - 1;
  localparam int PHASE_W          = 3;
  localparam int LP_PERIOD        = 8;
  localparam int LP_CAPTURE_PHASE = 7;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    NORMAL = 1'b0,
    LOWPWR = 1'b1
  } mode_e;

  // |x| with the most negative code saturating to the largest positive magnitude.
  function automatic logic [MAG_W-1:0] sample_mag(input sample_t x);
    logic [SAMPLE_W-1:0] a;
    a = x[SAMPLE_W-1] ? SAMPLE_W'(~x + SAMPLE_W'(1)) : SAMPLE_W'(x);
    return a[SAMPLE_W-1] ? {MAG_W{1'b1}} : a[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/dvs_sample_fifo.sv
// Synchronous sample FIFO; head entry visible combinationally, a push is poppable next cycle.
// Push is ignored when full (even with a simultaneous pop); pop is ignored when empty.
module dvs_sample_fifo
  import dvs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  sample_t                  push_dat,
  input  logic                     pop,
  output sample_t                  pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  sample_t         mem_q [DEPTH];
  sample_t         mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dvs_sample_feeder.sv
// Feeds the DVS filter: FIFO-buffered samples, activity-driven power mode, decimation phase mirror.
// One registered cycle from FIFO head to sample_out; upstream throttled by in_ready (FIFO not full).
module dvs_sample_feeder
  import dvs_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int THRESH      = 256,
  parameter int QUIET_COUNT = 16,
  parameter int EXIT_LEVEL  = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  sample_t                  in_data,
  output logic                     in_ready,
  output sample_t                  sample_out,
  output logic                     low_power_mode,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [MAG_W-1:0]   THRESH_M  = MAG_W'(THRESH);
  localparam logic [7:0]         QUIET_M   = 8'(QUIET_COUNT);
  localparam logic [LW-1:0]      EXIT_M    = LW'(EXIT_LEVEL);
  localparam logic [PHASE_W-1:0] POP_PHASE = PHASE_W'(LP_CAPTURE_PHASE - 1);
  localparam logic [PHASE_W-1:0] LAST_PH   = PHASE_W'(LP_PERIOD - 1);

  mode_e                mode_q, mode_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [7:0]           quiet_q, quiet_d;
  logic                 loud_q, loud_d;
  sample_t              sample_q, sample_d;
  logic                 underrun_q, underrun_d;

  logic                 fifo_full;
  logic                 fifo_empty;
  sample_t              head;
  logic                 pop_slot;
  logic                 do_pop;
  logic                 head_loud;

  dvs_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (in_valid),
    .push_dat (in_data),
    .pop      (do_pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign in_ready       = !fifo_full;
  assign sample_out     = sample_q;
  assign underrun       = underrun_q;
  assign low_power_mode = (mode_q == LOWPWR);

  // In low power the pop lands one cycle before the filter's capture phase.
  assign pop_slot  = (mode_q == NORMAL) || (phase_q == POP_PHASE);
  assign do_pop    = pop_slot && !fifo_empty;
  assign head_loud = (sample_mag(head) >= THRESH_M);

  always_comb begin
    sample_d   = sample_q;
    underrun_d = 1'b0;
    loud_d     = 1'b0;
    quiet_d    = quiet_q;
    mode_d     = mode_q;
    phase_d    = phase_q;

    if (pop_slot) begin
      if (!fifo_empty) begin
        sample_d = head;
        loud_d   = head_loud;
        if (head_loud) begin
          quiet_d = '0;
        end else if (quiet_q < QUIET_M) begin
          quiet_d = quiet_q + 8'd1;
        end
      end else begin
        sample_d   = '0;
        underrun_d = 1'b1;
        quiet_d    = '0;
      end
    end

    if (mode_q == LOWPWR) begin
      phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PHASE_W'(1);
    end

    case (mode_q)
      NORMAL: begin
        if (quiet_q >= QUIET_M) begin
          mode_d = LOWPWR;
        end
      end
      LOWPWR: begin
        if (loud_q || (fifo_level >= EXIT_M)) begin
          mode_d  = NORMAL;
          quiet_d = '0;
        end
      end
      default: mode_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q     <= NORMAL;
      phase_q    <= '0;
      quiet_q    <= '0;
      loud_q     <= 1'b0;
      sample_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      quiet_q    <= quiet_d;
      loud_q     <= loud_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: doc/dvs_sample_feeder.md
# dvs_sample_feeder

Upstream companion of the DVS moving-average filter. It accepts 16-bit signed samples over a valid/ready handshake and buffers them in a small FIFO. It drives the filter's `data_in` and `low_power_mode` inputs, deciding the power mode from signal activity. In low-power mode it mirrors the filter's 8-cycle decimation phase, so every sample the filter captures is a fresh FIFO entry and no sample is lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 4.
- `THRESH`, 256: quiet threshold on |sample|, unsigned 15-bit.
- `QUIET_COUNT`, 16: consecutive quiet pops needed to enter low-power mode; range 1–255.
- `EXIT_LEVEL`, 6: FIFO occupancy that forces exit from low-power mode; must be ≤ `DEPTH`.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream sample valid.
- `in_data` in 16: signed upstream sample.
- `in_ready` out 1: FIFO not full (combinational).
- `sample_out` out 16: signed, registered; connects to filter `data_in`.
- `low_power_mode` out 1: registered; connects to filter `low_power_mode`.
- `underrun` out 1: one-cycle pulse when a pop slot finds the FIFO empty.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Reset values:** `sample_out`=0, `low_power_mode`=0, phase=0, quiet count=0, FIFO empty, `fifo_level`=0, `underrun`=0. `in_ready`=1 during and after reset.
- **Push:** occurs when `in_valid && in_ready`. There is no push when full, even if a pop happens in the same cycle.
- **Phase mirror:** a 3-bit phase register follows the filter's counter.
  - When `low_power_mode`=1, it increments every cycle and wraps 7→0.
  - When `low_power_mode`=0, it holds its value and is never cleared on a mode change.
- **Pop slot:**
  - Normal mode: every cycle.
  - Low-power mode: only the cycle with phase==6, so `sample_out` is new during the phase==7 cycle, when the filter captures it.
- **Pop slot, FIFO non-empty:** `sample_out` ← head entry.
- **Pop slot, FIFO empty:** `sample_out` ← 0 and `underrun` pulses for one cycle.
- **Outside a pop slot:** `sample_out` holds.
- **Activity measure:** |x|, with -32768 saturating to 32767.
- **Quiet counter:** on each pop, it increments (saturating at `QUIET_COUNT`) if |x| < `THRESH`. It clears if |x| ≥ `THRESH` or on an underrun slot.
- **Mode FSM:** two states, NORMAL and LOWPWR.
  - NORMAL → LOWPWR: at the edge after the quiet count reaches `QUIET_COUNT`.
  - LOWPWR → NORMAL: at the edge after a popped sample has |x| ≥ `THRESH`, or when `fifo_level` ≥ `EXIT_LEVEL`. The quiet count clears on this exit.
  - Exit has priority if entry and exit conditions are both true.
- **Mode-change edge:** the pop decision for that edge uses the old mode.

## Timing
- **Latency:** a push at edge k is poppable at edge k+1, so `sample_out` shows the value after edge k+1 in normal mode with an empty FIFO. There is no bypass path.
- **Throughput:** normal mode sustains one sample per cycle. Low-power mode sustains one sample per 8 cycles, with upstream throttled by `in_ready`.
- **Mode update:** `low_power_mode` changes only on a clock edge and has no combinational path from inputs.
- **Reset mid-operation:** FIFO contents are discarded and all state returns to reset values immediately. The filter resets from the same net, so the phase stays aligned.

## Structure
- **Package `dvs_pkg`:**
  - constants: `SAMPLE_W`=16, `PHASE_W`=3, `LP_PERIOD`=8, `LP_CAPTURE_PHASE`=7;
  - the `sample_t` typedef;
  - the `mode_e` enum {NORMAL, LOWPWR}.
- **Sub-module `dvs_sample_fifo`:** synchronous FIFO.
  - Parameter: `DEPTH`.
  - Ports: push/pop/data/full/empty/level.
  - Read data comes from the head register with no registered-output latency.
- **Top level:** the phase mirror, quiet counter, mode FSM, and `sample_out` register.

## Test plan
- **Reset and normal stream:** release reset, push 1,2,3 on consecutive cycles. Expect `sample_out` = 1,2,3 on cycles 2–4, then 0 with an `underrun` pulse each cycle after.
- **Entry to low power:** push 16 samples of value 10 at one per cycle. Expect `low_power_mode`=1 on the edge after the 16th pop. Then expect `sample_out` updates only when the phase becomes 7, once every 8 cycles.
- **Exit on activity:** in LOWPWR, queue 5, 300. Expect 5 to be presented, then 300 at the next phase-7 cycle, then `low_power_mode`=0 one edge later with phase frozen.
- **Exit on backlog:** in LOWPWR, hold `in_valid`=1 with value 0. Expect exit when `fifo_level` reaches 6, then `in_ready` drops at level 8 only if exit has not yet drained the FIFO.
- **Boundary magnitudes:** -32768 counts as loud; -255 and 255 count as quiet; ±256 count as loud. Verify the quiet counter clears or increments accordingly.
- **Reset mid-LOWPWR:** assert `reset_n`=0 with phase=5 and the FIFO holding 3 entries. Expect all outputs at reset values and `fifo_level`=0 asynchronously.
